// File: rtl/port_filter.sv
// port_filter: input conditioning in front of the MCU core.
// 17 raw pins (ports A-D plus the active-low interrupt pin) are synchronised
// and then debounced on a shared sample tick. The outputs are clean levels
// plus a one-clock change pulse for the port bits.
// Optional feature macro: PORT_FILTER_INT_EN. When it is defined, any filtered
// change on port A also drives _INT low for INT_PULSE clocks.
module port_filter #(
    parameter int DIV       = 64,
    parameter int DEB       = 4,
    parameter int INT_PULSE = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] raw_a,
    input  logic [3:0] raw_b,
    input  logic [3:0] raw_c,
    input  logic [3:0] raw_d,
    input  logic       raw_int_n,
    output logic [3:0] prtAI,
    output logic [3:0] prtBI,
    output logic [3:0] prtCI,
    output logic [3:0] prtDI,
    output logic       _INT,
    output logic       chg
);
    localparam int NB = 17;            // 16 port bits + interrupt bit
    localparam int DW = $clog2(DIV);
    localparam int CW = $clog2(DEB);

    logic [NB-1:0]         raw_w, s1_q, s2_q, filt_q, filt_d;
    logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]         div_q;
    logic                  tick;
    logic [15:0]           prev_q;
    logic                  chg_q;

    // Bit layout: [3:0]=A, [7:4]=B, [11:8]=C, [15:12]=D, [16]=interrupt.
    assign raw_w = {raw_int_n, raw_d, raw_c, raw_b, raw_a};

    // Two-flop synchroniser; resets high to match pulled-up idle pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= raw_w;
            s2_q <= s1_q;
        end
    end

    // Shared sample-tick divider. The first tick comes DIV clocks after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_q <= '0;
        else        div_q <= tick ? '0 : div_q + 1'b1;
    end

    assign tick = (div_q == DW'(DIV - 1));

    // Per-bit debounce. A new level is accepted only after DEB consecutive
    // disagreeing ticks. Any agreeing tick restarts the count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (tick) begin
            for (int b = 0; b < NB; b++) begin
                if (s2_q[b] == filt_q[b]) begin
                    cnt_d[b] = '0;
                end else if (cnt_q[b] == CW'(DEB - 1)) begin
                    filt_d[b] = s2_q[b];
                    cnt_d[b]  = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // Filter state, and a change pulse raised one clock after a port update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            filt_q <= '1;
            prev_q <= '1;
            chg_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            prev_q <= filt_q[15:0];
            chg_q  <= |(filt_q[15:0] ^ prev_q);
        end
    end

    assign prtAI = filt_q[3:0];
    assign prtBI = filt_q[7:4];
    assign prtCI = filt_q[11:8];
    assign prtDI = filt_q[15:12];
    assign chg   = chg_q;

`ifdef PORT_FILTER_INT_EN
    localparam int PW = $clog2(INT_PULSE + 1);

    logic [PW-1:0] pls_q, pls_d;
    logic          a_upd;
    logic          int_q;

    // A port-A update (re)loads the pulse at full width on the same edge.
    always_comb begin
        a_upd = (filt_d[3:0] != filt_q[3:0]);
        pls_d = pls_q;
        if (a_upd)              pls_d = PW'(INT_PULSE);
        else if (pls_q != '0)   pls_d = pls_q - 1'b1;
    end

    // Registered _INT: the filtered pin, forced low while a pulse is active.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pls_q <= '0;
            int_q <= 1'b1;
        end else begin
            pls_q <= pls_d;
            int_q <= filt_d[16] & (pls_d == '0);
        end
    end

    assign _INT = int_q;
`else
    // Without the merge, INT_PULSE has no hardware behind it.
    logic unused_int_pulse;
    assign unused_int_pulse = (INT_PULSE > 0);
    assign _INT = filt_q[16];
`endif

endmodule

// File: tb/tb_port_filter.sv
// tb_port_filter: table-driven directed vectors, multi-cycle corner sequences
// and random stimulus, all checked every cycle against a window-based model.
module tb_port_filter;
    localparam int DIV       = 4;
    localparam int DEB       = 3;
    localparam int INT_PULSE = 8;
`ifdef PORT_FILTER_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] raw_a = 4'hF, raw_b = 4'hF, raw_c = 4'hF, raw_d = 4'hF;
    logic       raw_int_n = 1'b1;
    logic [3:0] prtAI, prtBI, prtCI, prtDI;
    logic       int_o, chg;

    int checks = 0;
    int errors = 0;

    port_filter #(.DIV(DIV), .DEB(DEB), .INT_PULSE(INT_PULSE)) dut (
        .clk(clk), .reset(reset),
        .raw_a(raw_a), .raw_b(raw_b), .raw_c(raw_c), .raw_d(raw_d),
        .raw_int_n(raw_int_n),
        .prtAI(prtAI), .prtBI(prtBI), .prtCI(prtCI), .prtDI(prtDI),
        ._INT(int_o), .chg(chg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- reference model ----------------
    // Pin seen by the filter at edge e is the pin sampled at edge e-2.
    // A bit flips on a tick if the last DEB tick samples all oppose it.
    // Port-A changes open an INT_PULSE-clock low window on _INT.
    int          e;
    logic [16:0] hist[$];
    logic [16:0] tq[$];
    logic [16:0] mf, mf_prev;
    logic        m_chg, m_int;
    int          lastA;

    task automatic mreset();
        e = 0;
        hist.delete();
        tq.delete();
        mf = '1;
        mf_prev = '1;
        m_chg = 1'b0;
        m_int = 1'b1;
        lastA = -1000;
    endtask

    task automatic mstep();
        logic [16:0] syn, newf;
        bit all_diff;
        e++;
        hist.push_front({raw_int_n, raw_d, raw_c, raw_b, raw_a});
        if (hist.size() > 3) void'(hist.pop_back());
        syn  = (hist.size() == 3) ? hist[2] : 17'h1FFFF;
        newf = mf;
        if (e % DIV == 0) begin
            tq.push_front(syn);
            if (tq.size() > DEB) void'(tq.pop_back());
            if (tq.size() == DEB) begin
                for (int b = 0; b < 17; b++) begin
                    all_diff = 1'b1;
                    foreach (tq[i]) if (tq[i][b] == mf[b]) all_diff = 1'b0;
                    if (all_diff) newf[b] = ~mf[b];
                end
            end
        end
        m_chg = (mf[15:0] != mf_prev[15:0]);
        if (newf[3:0] != mf[3:0]) lastA = e;
        mf_prev = mf;
        mf = newf;
        m_int = mf[16] & ~(INT_EN && (e - lastA) < INT_PULSE);
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) mreset();
            else        mstep();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("model", {prtAI, prtBI, prtCI, prtDI, int_o, chg},
                  {mf[3:0], mf[7:4], mf[11:8], mf[15:12], m_int, m_chg});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0] a, b, c, d;
        logic       n;
        int         hold;
        logic [3:0] ea, eb, ec, ed;
        logic       en;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int k;
        logic flag;
        logic [16:0] r;

        tbl[0] = '{4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 16, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1};
        tbl[1] = '{4'hF, 4'h5, 4'hF, 4'hF, 1'b1, 16, 4'hF, 4'h5, 4'hF, 4'hF, 1'b1};
        tbl[2] = '{4'hF, 4'h5, 4'hB, 4'hF, 1'b1,  7, 4'hF, 4'h5, 4'hF, 4'hF, 1'b1};
        tbl[3] = '{4'hF, 4'h5, 4'hF, 4'hF, 1'b1, 16, 4'hF, 4'h5, 4'hF, 4'hF, 1'b1};
        tbl[4] = '{4'hF, 4'h5, 4'hF, 4'h0, 1'b1, 16, 4'hF, 4'h5, 4'hF, 4'h0, 1'b1};
        tbl[5] = '{4'hE, 4'h5, 4'hF, 4'h0, 1'b1, 24, 4'hE, 4'h5, 4'hF, 4'h0, 1'b1};
        tbl[6] = '{4'hE, 4'h5, 4'hF, 4'h0, 1'b0, 16, 4'hE, 4'h5, 4'hF, 4'h0, 1'b0};
        tbl[7] = '{4'hE, 4'hA, 4'h6, 4'h9, 1'b1, 16, 4'hE, 4'hA, 4'h6, 4'h9, 1'b1};
        tbl[8] = '{4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 24, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1};

        // Reset values while reset is held low.
        repeat (2) @(negedge clk);
        check("rst_ports", {prtAI, prtBI, prtCI, prtDI}, 16'hFFFF);
        check("rst_int", int_o, 1'b1);
        check("rst_chg", chg, 1'b0);

        // Stable change on port B: latency window, then a single chg pulse.
        @(negedge clk);
        reset = 1'b1;
        raw_b = 4'h5;
        k = 0;
        while (prtBI != 4'h5 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check_rng("b_latency", k, 11, 14);
        check("b_others", {prtAI, prtCI, prtDI}, 12'hFFF);
        check("b_chg_same", chg, 1'b0);
        @(negedge clk);
        check("b_chg_next", chg, 1'b1);
        @(negedge clk);
        check("b_chg_end", chg, 1'b0);

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            raw_a = tbl[i].a; raw_b = tbl[i].b; raw_c = tbl[i].c; raw_d = tbl[i].d;
            raw_int_n = tbl[i].n;
            repeat (tbl[i].hold) @(negedge clk);
            check($sformatf("vec%0d_ports", i), {prtAI, prtBI, prtCI, prtDI},
                  {tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ed});
            check($sformatf("vec%0d_int", i), int_o, tbl[i].en);
        end

        // Interrupted count on raw_d[0]: 9 low, 4 high, then hold low.
        // Phase chosen so the first low run spans only DEB-1 ticks.
        for (int w = 0; w < 8 && ((e + 1) % DIV) != 3; w++) @(negedge clk);
        flag = 1'b0;
        raw_d[0] = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (prtDI != 4'hF) flag = 1'b1;
        end
        raw_d[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (prtDI != 4'hF) flag = 1'b1;
        end
        raw_d[0] = 1'b0;
        check("d_no_early", flag, 1'b0);
        k = 0;
        while (prtDI[0] != 1'b0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check_rng("d_latency", k, 11, 14);

        // Interrupt pin, then reset mid-count.
        raw_int_n = 1'b0;
        k = 0;
        while (int_o != 1'b0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check_rng("int_latency", k, 11, 14);
        raw_int_n = 1'b1;
        repeat (6) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_int", int_o, 1'b1);
        check("midrst_ports", {prtAI, prtBI, prtCI, prtDI}, 16'hFFFF);
        check("midrst_chg", chg, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);

`ifdef PORT_FILTER_INT_EN
        // Port-A change drives an 8-clock low pulse on _INT.
        raw_a = 4'hE;
        k = 0;
        while (prtAI != 4'hE && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("pulse_same_edge", int_o, 1'b0);
        k = 0;
        while (int_o == 1'b0 && k < 40) begin
            k++;
            @(negedge clk);
        end
        check("pulse_width", k, 8);
        repeat (10) @(negedge clk);

        // Second port-A update one tick into the pulse restarts it.
        raw_a = 4'hC;
        repeat (DIV) @(negedge clk);
        raw_a = 4'h8;
        k = 0;
        while (prtAI != 4'hC && k < 30) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (int_o == 1'b0 && k < 40) begin
            k++;
            @(negedge clk);
        end
        check("pulse_restart", k, DIV + INT_PULSE);
        raw_a = 4'hF;
        repeat (30) @(negedge clk);
`endif

        // Random stimulus with sparse bit flips, random holds and resets.
        for (int s = 0; s < 90; s++) begin
            r = {raw_int_n, raw_d, raw_c, raw_b, raw_a};
            r = r ^ 17'($urandom & $urandom & $urandom);
            @(negedge clk);
            {raw_int_n, raw_d, raw_c, raw_b, raw_a} = r;
            repeat ($urandom_range(1, 24)) @(negedge clk);
            if ($urandom_range(0, 29) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
        end
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
